// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Purpose : Shared types and constants for the ALU result BCD converter.
// Rev     : 1.0  initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Decimal digits needed for a 2N-bit unsigned value: ceil(2N/3).
    function automatic int calc_digits(input int n);
        return (2 * n + 2) / 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
`default_nettype none
// ============================================================================
// Module  : bcd_digit_adjust
// Purpose : Double-dabble digit correction: adds 3 to a BCD digit >= 5.
// Rev     : 1.0  initial release
// ============================================================================
module bcd_digit_adjust (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule
`default_nettype wire

// File: rtl/result_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module  : result_bcd_converter
// Purpose : Serial double-dabble conversion of a 2N-bit ALU result to BCD.
//           Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Rev     : 1.0  initial release
// ============================================================================
module result_bcd_converter
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [2*N-1:0]                    resultado,
    input  logic [3:0]                        banderas,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [4*calc_digits(N)-1:0]       bcd,
    output logic [3:0]                        flags_out,
    output logic                              busy
);

    localparam int W      = 2 * N;
    localparam int DIGITS = calc_digits(N);
    localparam int BW     = 4 * DIGITS;
    localparam int CW     = $clog2(W + 1);

    state_t          state_q,     state_d;
    logic [W-1:0]    sr_q,        sr_d;
    logic [BW-1:0]   acc_q,       acc_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic [BW-1:0]   bcd_q,       bcd_d;
    logic [3:0]      flags_q,     flags_d;
    logic            out_valid_q, out_valid_d;

    logic [BW-1:0]   w_adj;
    logic [BW-1:0]   w_shifted;
    logic [BW-1:0]   w_final;
    logic            w_unused_msb;

    genvar gd;
    generate
        for (gd = 0; gd < DIGITS; gd++) begin : g_adjust
            bcd_digit_adjust u_adjust (
                .i_digit (acc_q[4*gd +: 4]),
                .o_digit (w_adj[4*gd +: 4])
            );
        end
    endgenerate

    // The accumulator is sized for the largest result, so its top bit never
    // carries out of the shift.
    assign w_shifted    = {w_adj[BW-2:0], sr_q[W-1]};
    assign w_unused_msb = w_adj[BW-1];

`ifdef LEADING_ZERO_BLANK_EN
    logic w_seen_nonzero;

    always_comb begin
        w_final        = w_shifted;
        w_seen_nonzero = 1'b0;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (!w_seen_nonzero && (w_shifted[4*d +: 4] == 4'd0)) begin
                w_final[4*d +: 4] = BLANK_CODE;
            end else begin
                w_seen_nonzero = 1'b1;
            end
        end
    end
`else
    assign w_final = w_shifted;
`endif

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sr_d    = resultado;
                    flags_d = banderas;
                    acc_d   = '0;
                    cnt_d   = CW'(W);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc_d = w_shifted;
                sr_d  = sr_q << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d       = w_final;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE)  && !rst;
    assign busy      = (state_q == ST_SHIFT) && !rst;
    assign out_valid = out_valid_q;
    assign bcd       = bcd_q;
    assign flags_out = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_result_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module  : tb_result_bcd_converter
// Purpose : Directed plus randomized bench for result_bcd_converter (N=4).
// Rev     : 1.0  initial release
// ============================================================================
module tb_result_bcd_converter;

    localparam int N = 4;
    localparam int W = 2 * N;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  resultado;
    logic [3:0]  banderas;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] bcd;
    logic [3:0]  flags_out;
    logic        busy;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [11:0] prev_bcd;

    result_bcd_converter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .resultado (resultado),
        .banderas  (banderas),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .flags_out (flags_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Decimal digits by division, then optional blanking of leading zeros.
    function automatic logic [11:0] model_bcd(input int v);
        logic [11:0] r;
        int          x;
        r = '0;
        x = v;
        for (int d = 0; d < 3; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
`ifdef LEADING_ZERO_BLANK_EN
        for (int d = 2; d >= 1; d--) begin
            if (r[4*d +: 4] != 4'd0) break;
            r[4*d +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic convert(input logic [7:0] v, input logic [3:0] f, input int hold,
                           input bit inject, input bit valid_in_done, input logic [7:0] next_v);
        logic [11:0] e;
        e = model_bcd(int'(v));
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        resultado = v;
        banderas  = f;
        out_ready = (hold == 0);
        tick();
        in_valid  = 1'b0;
        resultado = 8'($urandom);
        banderas  = 4'($urandom);
        check("busy_after_accept",  32'(busy),      32'd1);
        check("in_ready_shift",     32'(in_ready),  32'd0);
        check("flags_captured",     32'(flags_out), 32'(f));
        check("bcd_holds_prev",     32'(bcd),       32'(prev_bcd));
        for (int i = 1; i < W; i++) begin
            if (inject && i == 2) begin
                in_valid  = 1'b1;
                resultado = 8'd77;
            end
            tick();
            in_valid = 1'b0;
            check("no_early_valid", 32'(out_valid), 32'd0);
            check("bcd_stable_shift", 32'(bcd), 32'(prev_bcd));
        end
        tick();
        check("out_valid_at_2n", 32'(out_valid), 32'd1);
        check("bcd_result",      32'(bcd),       32'(e));
        check("flags_result",    32'(flags_out), 32'(f));
        check("busy_done",       32'(busy),      32'd0);
        check("in_ready_done",   32'(in_ready),  32'd0);
        for (int k = 0; k < hold; k++) begin
            tick();
            check("valid_held", 32'(out_valid), 32'd1);
            check("bcd_held",   32'(bcd),       32'(e));
            check("flags_held", 32'(flags_out), 32'(f));
        end
        if (valid_in_done) begin
            in_valid  = 1'b1;
            resultado = next_v;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("valid_drop", 32'(out_valid), 32'd0);
        check("busy_idle",  32'(busy),      32'd0);
        check("ready_idle", 32'(in_ready),  32'd1);
        prev_bcd = e;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        resultado = '0;
        banderas  = '0;
        prev_bcd  = '0;

        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_bcd",       32'(bcd),       32'd0);
        check("rst_flags",     32'(flags_out), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        in_valid  = 1'b1;
        resultado = 8'd55;
        tick();
        check("rst_ignores_valid", 32'(busy), 32'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check("ready_after_rst", 32'(in_ready), 32'd1);

        convert(8'd255, 4'b0100, 0, 1'b0, 1'b0, 8'd0);
        convert(8'd0,   4'b0010, 0, 1'b0, 1'b0, 8'd0);
        convert(8'd9,   4'b0000, 5, 1'b0, 1'b0, 8'd0);
        convert(8'd128, 4'b1000, 1, 1'b1, 1'b0, 8'd0);

        // Reset on the 4th SHIFT cycle abandons the conversion.
        in_valid  = 1'b1;
        resultado = 8'd200;
        banderas  = 4'b0001;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_bcd",       32'(bcd),       32'd0);
        check("midrst_flags",     32'(flags_out), 32'd0);
        check("midrst_busy",      32'(busy),      32'd0);
        rst = 1'b0;
        #1;
        check("midrst_idle", 32'(in_ready), 32'd1);
        prev_bcd = '0;
        convert(8'd42, 4'b0000, 0, 1'b0, 1'b0, 8'd0);

        convert(8'd99,  4'b0110, 0, 1'b0, 1'b1, 8'd100);
        convert(8'd100, 4'b1001, 0, 1'b0, 1'b0, 8'd0);

        for (int r = 0; r < 20; r++) begin
            convert(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'b0, 8'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/result_bcd_converter.md
RESULT_BCD_CONVERTER -- requirements
Module: result_bcd_converter

Interface
REQ-001 Parameter N, default 4; ALU operand width, so the result width is 2N.
REQ-002 Derived constant DIGITS = (2N+2)/3 (integer division); 3 for N=4.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  resultado/banderas from the ALU are valid.
REQ-006 in_ready  output  1  converter can accept a new result.
REQ-007 resultado  input  2N  unsigned ALU result.
REQ-008 banderas  input  4  ALU flags; bits [3] overflow, [2] carry, [1] zero, [0] borrow.
REQ-009 out_valid  output  1  bcd/flags_out hold a completed conversion.
REQ-010 out_ready  input  1  consumer (display driver) accepts the output.
REQ-011 bcd  output  4*DIGITS  packed BCD digits, most significant digit in the top nibble.
REQ-012 flags_out  output  4  banderas as captured with the result being converted.
REQ-013 busy  output  1  high while a conversion is in progress (SHIFT state).

Function
REQ-014 FSM states: IDLE, SHIFT, DONE.
REQ-015 IDLE: in_ready=1; on in_valid&&in_ready, capture resultado into a shift register, capture banderas into flags_out, clear the BCD accumulator, load counter=2N, go to SHIFT.
REQ-016 SHIFT: each cycle, add 3 to every accumulator digit >=5, then shift {accumulator, shift register} left by one; decrement the counter.
REQ-017 SHIFT: when the counter reaches 0 after the final shift (2N shifts total), go to DONE.
REQ-018 out_valid rises exactly 2N clock edges after the accepting edge; 8 cycles for N=4.
REQ-019 DONE: out_valid=1; bcd and flags_out stay stable until out_ready=1, then go to IDLE.
REQ-020 in_ready=0 in SHIFT and DONE; in_valid in those states is ignored and not queued.
REQ-021 DONE with out_ready=1 does not accept a new input on the same edge; the next acceptance is earliest one cycle later, in IDLE.
REQ-022 out_ready is ignored outside DONE.
REQ-023 bcd is updated only on entry to DONE; it holds the previous conversion during SHIFT.
REQ-024 Every digit of bcd is always in the range 0..9, except for the blank code under REQ-029.

Reset
REQ-025 With rst=1 at a rising edge: state=IDLE, out_valid=0, bcd=0, flags_out=0, counter=0, accumulator=0.
REQ-026 While rst=1: in_ready=0 and busy=0.
REQ-027 Reset mid-SHIFT or in DONE abandons the conversion; no partial result ever appears on bcd.

Configuration
REQ-028 Macro LEADING_ZERO_BLANK_EN selects leading-zero blanking.
REQ-029 With LEADING_ZERO_BLANK_EN defined: in DONE, each leading zero digit above the least significant digit is replaced by BLANK_CODE=4'hF; the least significant digit is never blanked.
REQ-030 Without LEADING_ZERO_BLANK_EN: raw BCD digits are output; no blank logic is synthesised.

Structure
REQ-031 Shared package alu_pkg holds the state enum type, the DIGITS computation function and the BLANK_CODE constant.
REQ-032 One sub-module, bcd_digit_adjust: combinational; a 4-bit digit in, the digit plus 3 out if it is >=5, otherwise unchanged.
REQ-033 result_bcd_converter instantiates bcd_digit_adjust DIGITS times.
REQ-034 Downstream of the ALU: resultado/banderas connect directly to the ALU outputs.

Verification
REQ-035 N=4, resultado=8'd255, banderas=4'b0100, out_ready=1 -> after 8 cycles bcd=12'h255, flags_out=4'b0100, out_valid for one cycle.
REQ-036 resultado=8'd0, banderas=4'b0010 -> bcd=12'h000 without the macro, 12'hFF0 with LEADING_ZERO_BLANK_EN; flags_out=4'b0010.
REQ-037 resultado=8'd9, out_ready held low 5 cycles after out_valid -> bcd=12'h009 held stable, out_valid high all 5 cycles; IDLE one cycle after out_ready rises.
REQ-038 Accept 8'd128, then pulse in_valid with 8'd77 during SHIFT -> the second input is ignored; bcd=12'h128.
REQ-039 Accept 8'd200, assert rst on the 4th SHIFT cycle -> next cycle out_valid=0, bcd=0, IDLE; a new 8'd42 then yields 12'h042.
REQ-040 Back-to-back results 8'd99 then 8'd100 -> in_ready low from acceptance until one cycle after the first out handshake; outputs 12'h099 then 12'h100.
